// File: rtl/compound_producer.sv
// compound_producer: transmit end of the CompoundType blocking-port protocol.
// Ports: clk/rst (async, active-high); cmd_in/_sync/_notify burst command in;
//   b_out/_sync/_notify message stream out; m_out/m_out_notify completion report.
// b_out packing: [33] mode (0=read,1=write), [32:1] x (signed), [0] y (last).
// Optional macro COMPOUND_PRODUCER_TIMEOUT_EN: abort a stalled burst after
//   TIMEOUT cycles and report -1 - (messages completed).

package testbasic12_types;
   typedef enum logic {
      MODE_READ  = 1'b0,
      MODE_WRITE = 1'b1
   } mode_e;

   typedef struct packed {
      mode_e             mode;
      logic signed [31:0] x;
      logic              y;
   } CompoundType;
endpackage

module compound_producer
   import testbasic12_types::*;
#(
   parameter logic signed [31:0] BASE      = 0,
   parameter logic signed [31:0] STRIDE    = 1,
   parameter int                 MAX_BURST = 256,
   parameter int                 TIMEOUT   = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cmd_in,
   input  logic        cmd_in_sync,
   output logic        cmd_in_notify,
   output logic [33:0] b_out,
   input  logic        b_out_sync,
   output logic        b_out_notify,
   output logic [31:0] m_out,
   output logic        m_out_notify
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_REPORT
   } state_e;

   localparam logic signed [31:0] MAXB = MAX_BURST;

   state_e      state_q, state_d;
   CompoundType msg_q, msg_d;
   logic        cn_q, cn_d;
   logic        bn_q, bn_d;
   logic [31:0] m_q, m_d;
   logic        mn_q, mn_d;
   logic [31:0] len_q, len_d;
   logic [31:0] sent_q, sent_d;
`ifdef COMPOUND_PRODUCER_TIMEOUT_EN
   logic [31:0] wait_q, wait_d;
`endif

   logic signed [31:0] cmd_s;
   logic signed [31:0] clamp_len;

   assign cmd_s     = $signed(cmd_in);
   assign clamp_len = (cmd_s > MAXB) ? MAXB : cmd_s;

   always_comb begin
      state_d = state_q;
      msg_d   = msg_q;
      cn_d    = cn_q;
      bn_d    = bn_q;
      m_d     = m_q;
      mn_d    = 1'b0;
      len_d   = len_q;
      sent_d  = sent_q;
`ifdef COMPOUND_PRODUCER_TIMEOUT_EN
      wait_d  = wait_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (cmd_in_sync) begin
               cn_d = 1'b0;
               if (clamp_len <= 0) begin
                  // Empty burst: report zero without sending.
                  m_d     = '0;
                  mn_d    = 1'b1;
                  state_d = S_REPORT;
               end else begin
                  len_d      = clamp_len;
                  msg_d.mode = MODE_READ;
                  msg_d.x    = BASE;
                  msg_d.y    = (clamp_len == 32'sd1);
                  bn_d       = 1'b1;
                  sent_d     = '0;
`ifdef COMPOUND_PRODUCER_TIMEOUT_EN
                  wait_d     = '0;
`endif
                  state_d    = S_SEND;
               end
            end
         end
         S_SEND: begin
            if (b_out_sync) begin
`ifdef COMPOUND_PRODUCER_TIMEOUT_EN
               wait_d = '0;
`endif
               if (sent_q + 32'd1 == len_q) begin
                  bn_d    = 1'b0;
                  m_d     = len_q;
                  mn_d    = 1'b1;
                  state_d = S_REPORT;
               end else begin
                  sent_d     = sent_q + 32'd1;
                  msg_d.mode = (msg_q.mode == MODE_READ) ? MODE_WRITE : MODE_READ;
                  msg_d.x    = msg_q.x + STRIDE;
                  msg_d.y    = (sent_q + 32'd2 == len_q);
               end
            end
`ifdef COMPOUND_PRODUCER_TIMEOUT_EN
            else if (wait_q == 32'(TIMEOUT - 1)) begin
               // Encode completed count as a negative status.
               bn_d    = 1'b0;
               m_d     = 32'hFFFF_FFFF - sent_q;
               mn_d    = 1'b1;
               state_d = S_REPORT;
            end else begin
               wait_d = wait_q + 32'd1;
            end
`endif
         end
         S_REPORT: begin
            cn_d    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cn_d    = 1'b1;
            bn_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         msg_q   <= '0;
         cn_q    <= 1'b1;
         bn_q    <= 1'b0;
         m_q     <= '0;
         mn_q    <= 1'b0;
         len_q   <= '0;
         sent_q  <= '0;
`ifdef COMPOUND_PRODUCER_TIMEOUT_EN
         wait_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         msg_q   <= msg_d;
         cn_q    <= cn_d;
         bn_q    <= bn_d;
         m_q     <= m_d;
         mn_q    <= mn_d;
         len_q   <= len_d;
         sent_q  <= sent_d;
`ifdef COMPOUND_PRODUCER_TIMEOUT_EN
         wait_q  <= wait_d;
`endif
      end
   end

   assign cmd_in_notify = cn_q;
   assign b_out         = msg_q;
   assign b_out_notify  = bn_q;
   assign m_out         = m_q;
   assign m_out_notify  = mn_q;

endmodule

// File: tb/tb_compound_producer.sv
// Bench for compound_producer: three instances with different BASE/STRIDE
// share stimulus; a scoreboard checks every message and report.
module tb_compound_producer;

   localparam int N    = 3;
   localparam int MAXB = 256;
   localparam logic [31:0] P_BASE   [N] = '{32'd0, 32'd10, 32'h7FFF_FFFF};
   localparam logic [31:0] P_STRIDE [N] = '{32'd1, 32'hFFFF_FFFC, 32'd1};

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cmd_in;
   logic        cmd_in_sync;
   logic        b_out_sync;
   logic        cn [N];
   logic        bn [N];
   logic        mn [N];
   logic [33:0] bo [N];
   logic [31:0] mo [N];

   typedef struct packed {
      logic [33:0] m0;
      logic [33:0] m1;
      logic [33:0] m2;
   } exp_t;

   exp_t        q_msg [$];
   logic [31:0] q_rep [$];
   int errors = 0;
   int checks = 0;
   int xfers  = 0;
   int reps   = 0;

   always #5 clk = ~clk;

   compound_producer #(
      .BASE(P_BASE[0]), .STRIDE(P_STRIDE[0]), .MAX_BURST(MAXB), .TIMEOUT(8)
   ) dut0 (
      .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_in_sync(cmd_in_sync),
      .cmd_in_notify(cn[0]), .b_out(bo[0]), .b_out_sync(b_out_sync),
      .b_out_notify(bn[0]), .m_out(mo[0]), .m_out_notify(mn[0])
   );

   compound_producer #(
      .BASE(P_BASE[1]), .STRIDE(P_STRIDE[1]), .MAX_BURST(MAXB), .TIMEOUT(8)
   ) dut1 (
      .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_in_sync(cmd_in_sync),
      .cmd_in_notify(cn[1]), .b_out(bo[1]), .b_out_sync(b_out_sync),
      .b_out_notify(bn[1]), .m_out(mo[1]), .m_out_notify(mn[1])
   );

   compound_producer #(
      .BASE(P_BASE[2]), .STRIDE(P_STRIDE[2]), .MAX_BURST(MAXB), .TIMEOUT(8)
   ) dut2 (
      .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_in_sync(cmd_in_sync),
      .cmd_in_notify(cn[2]), .b_out(bo[2]), .b_out_sync(b_out_sync),
      .b_out_notify(bn[2]), .m_out(mo[2]), .m_out_notify(mn[2])
   );

   function automatic logic [33:0] mk(input int k, input int i, input int len);
      logic [31:0] x;
      logic        y;
      x = P_BASE[k] + P_STRIDE[k] * 32'(i);
      y = (i == len - 1);
      return {i[0], x, y};
   endfunction

   function automatic logic [33:0] sel(input exp_t e, input int k);
      case (k)
         0:       return e.m0;
         1:       return e.m1;
         default: return e.m2;
      endcase
   endfunction

   task automatic push_msgs(input int cmd, input int n);
      int   len;
      exp_t e;
      len = (cmd > MAXB) ? MAXB : cmd;
      if (n < 0 || n > len) n = len;
      for (int i = 0; i < n; i++) begin
         e.m0 = mk(0, i, len);
         e.m1 = mk(1, i, len);
         e.m2 = mk(2, i, len);
         q_msg.push_back(e);
      end
   endtask

   // Scoreboard and hold-stability monitor.
   logic        pbn [N];
   logic [33:0] pbo [N];
   logic        pxf;

   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] r;
      if (rst) begin
         for (int k = 0; k < N; k++) pbn[k] = 1'b0;
         pxf = 1'b0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (pbn[k] && !pxf) begin
`ifdef COMPOUND_PRODUCER_TIMEOUT_EN
               if (bn[k]) begin
                  checks++;
                  if (bo[k] !== pbo[k]) begin
                     errors++;
                     $display("FAIL hold dut%0d: got %h want %h", k, bo[k], pbo[k]);
                  end
               end
`else
               checks++;
               if (bn[k] !== 1'b1 || bo[k] !== pbo[k]) begin
                  errors++;
                  $display("FAIL hold dut%0d: got n=%b %h want n=1 %h",
                           k, bn[k], bo[k], pbo[k]);
               end
`endif
            end
         end
         if (bn[0] && b_out_sync) begin
            xfers++;
            if (q_msg.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_msg: got %h want none", bo[0]);
            end else begin
               e = q_msg.pop_front();
               for (int k = 0; k < N; k++) begin
                  checks++;
                  if (bn[k] !== 1'b1 || bo[k] !== sel(e, k)) begin
                     errors++;
                     $display("FAIL msg dut%0d: got n=%b %h want n=1 %h",
                              k, bn[k], bo[k], sel(e, k));
                  end
               end
            end
         end
         if (mn[0]) begin
            reps++;
            if (q_rep.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_report: got %h want none", mo[0]);
            end else begin
               r = q_rep.pop_front();
               for (int k = 0; k < N; k++) begin
                  checks++;
                  if (mn[k] !== 1'b1 || mo[k] !== r) begin
                     errors++;
                     $display("FAIL report dut%0d: got n=%b %h want n=1 %h",
                              k, mn[k], mo[k], r);
                  end
               end
            end
         end
         for (int k = 0; k < N; k++) begin
            pbn[k] = bn[k];
            pbo[k] = bo[k];
         end
         pxf = bn[0] && b_out_sync;
      end
   end

   task automatic send_cmd(input int v);
      bit ok;
      ok = 1'b0;
      cmd_in      = v;
      cmd_in_sync = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (cn[0]) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end
      end
      cmd_in_sync = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL cmd_accept: got notify=0 want 1 within 20 cycles");
      end
   endtask

   task automatic wait_report(input int budget);
      int r0;
      r0 = reps;
      for (int i = 0; i < budget && reps == r0; i++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (reps == r0) begin
         errors++;
         $display("FAIL report_timeout: got no pulse want pulse in %0d cycles", budget);
      end
   endtask

   task automatic test_reset;
      rst         = 1'b1;
      cmd_in      = '0;
      cmd_in_sync = 1'b0;
      b_out_sync  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         checks++;
         if ({cn[k], bn[k], bo[k], mo[k], mn[k]} !== {1'b1, 1'b0, 34'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset dut%0d: got cn=%b bn=%b bo=%h m=%h mn=%b want 1 0 0 0 0",
                     k, cn[k], bn[k], bo[k], mo[k], mn[k]);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_back_to_back;
      b_out_sync = 1'b1;
      push_msgs(3, -1);
      q_rep.push_back(32'd3);
      send_cmd(3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bn[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_valid[%0d]: got %b want 1", i, bn[0]);
         end
      end
      @(negedge clk);
      checks++;
      if ({mn[0], cn[0], bn[0]} !== 3'b100) begin
         errors++;
         $display("FAIL report_cycle: got mn,cn,bn=%b want 100", {mn[0], cn[0], bn[0]});
      end
      @(negedge clk);
      checks++;
      if ({mn[0], cn[0], bn[0]} !== 3'b010) begin
         errors++;
         $display("FAIL idle_return: got mn,cn,bn=%b want 010", {mn[0], cn[0], bn[0]});
      end
      @(posedge clk);
      #1;
      checks++;
      if (q_msg.size() != 0 || q_rep.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain: got %0d/%0d left want 0/0", q_msg.size(), q_rep.size());
      end
   endtask

   task automatic test_stall;
      b_out_sync = 1'b0;
      push_msgs(2, -1);
      q_rep.push_back(32'd2);
      send_cmd(2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bn[1] !== 1'b1 || bo[1] !== {1'b0, 32'd10, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got n=%b %h want n=1 %h",
                     i, bn[1], bo[1], {1'b0, 32'd10, 1'b0});
         end
      end
      @(posedge clk);
      #1;
      b_out_sync = 1'b1;
      wait_report(20);
      checks++;
      if (q_msg.size() != 0 || q_rep.size() != 0) begin
         errors++;
         $display("FAIL stall_drain: got %0d/%0d left want 0/0", q_msg.size(), q_rep.size());
      end
   endtask

   task automatic test_empty;
      int vals [2];
      vals[0] = 0;
      vals[1] = -7;
      b_out_sync = 1'b1;
      for (int j = 0; j < 2; j++) begin
         q_rep.push_back(32'd0);
         send_cmd(vals[j]);
         @(negedge clk);
         checks++;
         if ({mn[0], bn[0], mo[0]} !== {1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL empty_cmd(%0d): got mn=%b bn=%b m=%h want 1 0 0",
                     vals[j], mn[0], bn[0], mo[0]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_clamp_wrap;
      int x0;
      b_out_sync = 1'b1;
      push_msgs(1000, -1);
      q_rep.push_back(32'd256);
      x0 = xfers;
      send_cmd(1000);
      wait_report(300);
      checks++;
      if (xfers - x0 != 256 || q_msg.size() != 0 || q_rep.size() != 0) begin
         errors++;
         $display("FAIL clamp: got %0d msgs %0d left want 256 msgs 0 left",
                  xfers - x0, q_msg.size());
      end
   endtask

   task automatic test_reset_mid;
      b_out_sync = 1'b1;
      push_msgs(5, 2);
      send_cmd(5);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         checks++;
         if ({cn[k], bn[k], bo[k], mo[k], mn[k]} !== {1'b1, 1'b0, 34'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset dut%0d: got cn=%b bn=%b bo=%h m=%h mn=%b want 1 0 0 0 0",
                     k, cn[k], bn[k], bo[k], mo[k], mn[k]);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (q_msg.size() != 0 || q_rep.size() != 0) begin
         errors++;
         $display("FAIL mid_reset_count: got %0d/%0d left want 0/0", q_msg.size(), q_rep.size());
      end
      push_msgs(1, -1);
      q_rep.push_back(32'd1);
      send_cmd(1);
      wait_report(20);
      checks++;
      if (q_msg.size() != 0 || q_rep.size() != 0) begin
         errors++;
         $display("FAIL after_reset: got %0d/%0d left want 0/0", q_msg.size(), q_rep.size());
      end
   endtask

`ifdef COMPOUND_PRODUCER_TIMEOUT_EN
   task automatic test_timeout;
      int n;
      b_out_sync = 1'b1;
      push_msgs(4, 1);
      q_rep.push_back(32'hFFFF_FFFE);
      send_cmd(4);
      @(posedge clk);
      #1;
      b_out_sync = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bn[0]) n++;
         else break;
      end
      checks++;
      if (n != 8 || mn[0] !== 1'b1 || mo[0] !== 32'hFFFF_FFFE) begin
         errors++;
         $display("FAIL timeout: got stall=%0d mn=%b m=%h want 8 1 fffffffe",
                  n, mn[0], mo[0]);
      end
      @(posedge clk);
      #1;
      b_out_sync = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (q_msg.size() != 0 || q_rep.size() != 0 || cn[0] !== 1'b1) begin
         errors++;
         $display("FAIL timeout_drain: got %0d/%0d cn=%b want 0/0 1",
                  q_msg.size(), q_rep.size(), cn[0]);
      end
   endtask
`endif

   initial begin
      rst         = 1'b1;
      cmd_in      = '0;
      cmd_in_sync = 1'b0;
      b_out_sync  = 1'b0;
      test_reset();
      test_back_to_back();
      test_stall();
      test_empty();
      test_clamp_wrap();
      test_reset_mid();
`ifdef COMPOUND_PRODUCER_TIMEOUT_EN
      test_timeout();
`endif
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish by 500000");
      $fatal(1, "watchdog");
   end

endmodule
